// File: rtl/stack_pkg.sv
// Shared opcode encoding, operand-count helper and FSM states for the stack ALU engine.
package stack_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_PUSH  = 5'd1;
  localparam logic [4:0] OP_POP   = 5'd2;
  localparam logic [4:0] OP_DUP   = 5'd3;
  localparam logic [4:0] OP_SWAP  = 5'd4;
  localparam logic [4:0] OP_ADD   = 5'd5;
  localparam logic [4:0] OP_SUB   = 5'd6;
  localparam logic [4:0] OP_MUL   = 5'd7;
  localparam logic [4:0] OP_DIV   = 5'd8;
  localparam logic [4:0] OP_AND   = 5'd9;
  localparam logic [4:0] OP_NAND  = 5'd10;
  localparam logic [4:0] OP_OR    = 5'd11;
  localparam logic [4:0] OP_XOR   = 5'd12;
  localparam logic [4:0] OP_CMP   = 5'd13;
  localparam logic [4:0] OP_NOT   = 5'd14;
  localparam logic [4:0] OP_IF_EQ = 5'd15;
  localparam logic [4:0] OP_IF_GT = 5'd16;
  localparam logic [4:0] OP_IF_LT = 5'd17;
  localparam logic [4:0] OP_IF_GE = 5'd18;
  localparam logic [4:0] OP_IF_LE = 5'd19;

  typedef enum logic {IDLE, DIV} state_t;

  // Unassigned opcodes behave like NOP and therefore need no operands.
  function automatic logic [1:0] req_ops(input logic [4:0] op);
    case (op)
      OP_NOP, OP_PUSH:        req_ops = 2'd0;
      OP_POP, OP_DUP, OP_NOT: req_ops = 2'd1;
      default:                req_ops = (op <= OP_IF_LE) ? 2'd2 : 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is
// resolved on the start edge so done pulses WIDTH-1 cycles after start.
module serial_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem, quo, dsr;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [CNTW-1:0]  cnt;
  logic             running;

  // Shift the next dividend bit into the partial remainder and subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh, diff;
    sh   = {r, q[WIDTH-1]};
    diff = sh - {1'b0, d};
    if (!diff[WIDTH]) div_step = {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else              div_step = {sh[WIDTH-1:0],   q[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    // NOTE: combinational outputs are fully assigned on every path so no latch is inferred.
    if (start) {rem_nx, quo_nx} = div_step('0, dividend, divisor);
    else       {rem_nx, quo_nx} = div_step(rem, quo, dsr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem     <= '0;
      quo     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      done <= 1'b0;
      if (start) begin
        rem     <= rem_nx;
        quo     <= quo_nx;
        dsr     <= divisor;
        cnt     <= CNTW'(WIDTH - 1);
        running <= 1'b1;
      end else if (running) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt - CNTW'(1);
        if (cnt == CNTW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/stack_alu_engine.sv
// Operand stack with single-cycle ALU/compare ops and a serial divider,
// driven by a valid/ready command interface.
module stack_alu_engine
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    depth,
  output logic             busy,
  output logic             cond_flag,
  output logic             err_ovf,
  output logic             err_udf,
  output logic             err_dz
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state, state_nx;

  logic [AW-1:0]    t_idx, n_idx, p_idx;
  logic [WIDTH-1:0] t_val, n_val;
  logic             accept, udf, ovf, ok, div_start, div_done;
  logic [WIDTH-1:0] div_q;
  logic             is_lt, is_eq;
  logic [WIDTH-1:0] alu_res;
  logic             cond_res, is_alu2;
  logic             we0, we1;
  logic [AW-1:0]    wi0, wi1;
  logic [WIDTH-1:0] wd0, wd1;

  assign t_idx = AW'(depth - CW'(1));
  assign n_idx = AW'(depth - CW'(2));
  assign p_idx = AW'(depth);
  assign t_val = (depth != '0)      ? mem[t_idx] : '0;
  assign n_val = (depth >= CW'(2))  ? mem[n_idx] : '0;
  assign tos   = t_val;

  assign busy      = (state == DIV);
  assign cmd_ready = (state == IDLE);

  // Underflow takes priority so a DUP on an empty stack reports only udf.
  assign accept    = cmd_valid && cmd_ready;
  assign udf       = accept && (depth < CW'(req_ops(cmd_op)));
  assign ovf       = accept && !udf && ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP))
                     && (depth == CW'(DEPTH));
  assign ok        = accept && !udf && !ovf;
  assign div_start = ok && (cmd_op == OP_DIV) && (t_val != '0);

  assign is_lt = $signed(n_val) < $signed(t_val);
  assign is_eq = (n_val == t_val);

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (n_val),
    .divisor  (t_val),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    alu_res  = '0;
    cond_res = 1'b0;
    is_alu2  = 1'b0;
    case (cmd_op)
      OP_ADD:   begin alu_res = n_val + t_val;     is_alu2 = 1'b1; end
      OP_SUB:   begin alu_res = n_val - t_val;     is_alu2 = 1'b1; end
      OP_MUL:   begin alu_res = n_val * t_val;     is_alu2 = 1'b1; end
      OP_AND:   begin alu_res = n_val & t_val;     is_alu2 = 1'b1; end
      OP_NAND:  begin alu_res = ~(n_val & t_val);  is_alu2 = 1'b1; end
      OP_OR:    begin alu_res = n_val | t_val;     is_alu2 = 1'b1; end
      OP_XOR:   begin alu_res = n_val ^ t_val;     is_alu2 = 1'b1; end
      OP_CMP: begin
        alu_res = is_lt ? '1 : (is_eq ? '0 : WIDTH'(1));
        is_alu2 = 1'b1;
      end
      // Divide by zero finishes immediately with an all-ones quotient.
      OP_DIV:   begin alu_res = '1; is_alu2 = (t_val == '0); end
      OP_NOT:   alu_res  = ~t_val;
      OP_IF_EQ: cond_res = is_eq;
      OP_IF_GT: cond_res = !is_lt && !is_eq;
      OP_IF_LT: cond_res = is_lt;
      OP_IF_GE: cond_res = !is_lt;
      OP_IF_LE: cond_res = is_lt || is_eq;
      default:  ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (div_start) state_nx = DIV;
      DIV:     if (div_done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Two write ports: SWAP is the only op that touches two entries at once.
  always_comb begin
    we0 = 1'b0;
    wi0 = '0;
    wd0 = '0;
    we1 = 1'b0;
    wi1 = '0;
    wd1 = '0;
    if (state == DIV) begin
      if (div_done) begin
        we0 = 1'b1;
        wi0 = n_idx;
        wd0 = div_q;
      end
    end else if (ok) begin
      case (cmd_op)
        OP_PUSH: begin we0 = 1'b1; wi0 = p_idx; wd0 = cmd_data; end
        OP_DUP:  begin we0 = 1'b1; wi0 = p_idx; wd0 = t_val;    end
        OP_SWAP: begin
          we0 = 1'b1; wi0 = t_idx; wd0 = n_val;
          we1 = 1'b1; wi1 = n_idx; wd1 = t_val;
        end
        OP_NOT:  begin we0 = 1'b1; wi0 = t_idx; wd0 = alu_res;  end
        default: if (is_alu2) begin we0 = 1'b1; wi0 = n_idx; wd0 = alu_res; end
      endcase
    end
  end

  // NOTE: the storage array has no reset; depth=0 masks whatever it holds.
  always_ff @(posedge clk) begin
    if (we0) mem[wi0] <= wd0;
    if (we1) mem[wi1] <= wd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth     <= '0;
      dout      <= '0;
      cond_flag <= 1'b0;
      err_ovf   <= 1'b0;
      err_udf   <= 1'b0;
      err_dz    <= 1'b0;
    end else begin
      err_ovf <= ovf;
      err_udf <= udf;
      err_dz  <= ok && (cmd_op == OP_DIV) && (t_val == '0);
      if (state == DIV) begin
        if (div_done) begin
          depth <= depth - CW'(1);
          dout  <= div_q;
        end
      end else if (ok) begin
        case (cmd_op)
          OP_PUSH, OP_DUP: depth <= depth + CW'(1);
          OP_POP: begin
            dout  <= t_val;
            depth <= depth - CW'(1);
          end
          OP_NOT: dout <= alu_res;
          OP_IF_EQ, OP_IF_GT, OP_IF_LT, OP_IF_GE, OP_IF_LE: begin
            depth     <= depth - CW'(2);
            cond_flag <= cond_res;
          end
          default: if (is_alu2) begin
            depth <= depth - CW'(1);
            dout  <= alu_res;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stack_alu_engine.sv
// Self-checking bench: directed vector table, hand-written multi-cycle corners,
// and randomized commands against a queue-based reference model.
module tb_stack_alu_engine;
  import stack_pkg::*;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = $clog2(D + 1);

  logic          clk, reset_n, cmd_valid, cmd_ready, busy, cond_flag;
  logic          err_ovf, err_udf, err_dz;
  logic [4:0]    cmd_op;
  logic [W-1:0]  cmd_data, tos, dout;
  logic [CW-1:0] depth;

  stack_alu_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .tos       (tos),
    .dout      (dout),
    .depth     (depth),
    .busy      (busy),
    .cond_flag (cond_flag),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf),
    .err_dz    (err_dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: stack as a queue, back = top of stack.
  logic [W-1:0] mstk[$];
  logic [W-1:0] m_dout;
  logic         m_cond;
  logic [2:0]   m_err;  // {ovf, udf, dz}

  function automatic int needed(input logic [4:0] op);
    if (op == OP_NOP || op == OP_PUSH) return 0;
    if (op == OP_POP || op == OP_DUP || op == OP_NOT) return 1;
    return 2;
  endfunction

  task automatic model_step(input logic [4:0] op, input logic [W-1:0] data);
    logic [W-1:0] t, n, r;
    int sn, st;
    m_err = 3'b000;
    if (mstk.size() < needed(op)) begin m_err = 3'b010; return; end
    if ((op == OP_PUSH || op == OP_DUP) && mstk.size() == D) begin m_err = 3'b100; return; end
    t = (mstk.size() >= 1) ? mstk[mstk.size()-1] : '0;
    n = (mstk.size() >= 2) ? mstk[mstk.size()-2] : '0;
    sn = $signed(n);
    st = $signed(t);
    case (op)
      OP_NOP:  ;
      OP_PUSH: mstk.push_back(data);
      OP_POP:  m_dout = mstk.pop_back();
      OP_DUP:  mstk.push_back(t);
      OP_SWAP: begin
        mstk[mstk.size()-1] = n;
        mstk[mstk.size()-2] = t;
      end
      OP_NOT: begin
        r = ~t;
        mstk[mstk.size()-1] = r;
        m_dout = r;
      end
      OP_IF_EQ, OP_IF_GT, OP_IF_LT, OP_IF_GE, OP_IF_LE: begin
        void'(mstk.pop_back());
        void'(mstk.pop_back());
        case (op)
          OP_IF_EQ: m_cond = (sn == st);
          OP_IF_GT: m_cond = (sn > st);
          OP_IF_LT: m_cond = (sn < st);
          OP_IF_GE: m_cond = (sn >= st);
          default:  m_cond = (sn <= st);
        endcase
      end
      default: begin
        case (op)
          OP_ADD:  r = n + t;
          OP_SUB:  r = n - t;
          OP_MUL:  r = W'(32'(n) * 32'(t));
          OP_DIV:  r = (t == 0) ? {W{1'b1}} : n / t;
          OP_AND:  r = n & t;
          OP_NAND: r = ~(n & t);
          OP_OR:   r = n | t;
          OP_XOR:  r = n ^ t;
          default: r = (sn < st) ? {W{1'b1}} : ((sn == st) ? W'(0) : W'(1));
        endcase
        if (op == OP_DIV && t == 0) m_err = 3'b001;
        void'(mstk.pop_back());
        void'(mstk.pop_back());
        mstk.push_back(r);
        m_dout = r;
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] data);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 40) begin @(negedge clk); guard++; end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic compare_model(input string tag);
    logic [W-1:0] et;
    et = (mstk.size() > 0) ? mstk[mstk.size()-1] : '0;
    check({tag, " tos"},   32'(tos),       32'(et));
    check({tag, " depth"}, 32'(depth),     32'(mstk.size()));
    check({tag, " dout"},  32'(dout),      32'(m_dout));
    check({tag, " cond"},  32'(cond_flag), 32'(m_cond));
    check({tag, " err"},   32'({err_ovf, err_udf, err_dz}), 32'(m_err));
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mstk.delete();
    m_dout = '0;
    m_cond = 1'b0;
    m_err  = 3'b000;
  endtask

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] data;
    logic [W-1:0] tos;
    int           depth;
    logic [W-1:0] dout;
    logic         cond;
    logic [2:0]   err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] op, input logic [W-1:0] data, input logic [W-1:0] et,
                         input int ed, input logic [W-1:0] eo, input logic ec, input logic [2:0] ee);
    vec_t v;
    v.op = op; v.data = data; v.tos = et; v.depth = ed; v.dout = eo; v.cond = ec; v.err = ee;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    logic [4:0] op;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;

    //          op        data      tos      depth dout     cond  {ovf,udf,dz}
    add_vec(OP_PUSH,  16'd4,    16'd4,    1, 16'd0,    1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd2,    16'd2,    2, 16'd0,    1'b0, 3'b000);
    add_vec(OP_ADD,   16'd0,    16'd6,    1, 16'd6,    1'b0, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd0,    0, 16'd6,    1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd4,    16'd4,    1, 16'd6,    1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd2,    16'd2,    2, 16'd6,    1'b0, 3'b000);
    add_vec(OP_SUB,   16'd0,    16'd2,    1, 16'd2,    1'b0, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd0,    0, 16'd2,    1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd4,    16'd4,    1, 16'd2,    1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd2,    16'd2,    2, 16'd2,    1'b0, 3'b000);
    add_vec(OP_MUL,   16'd0,    16'd8,    1, 16'd8,    1'b0, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd0,    0, 16'd8,    1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd4,    16'd4,    1, 16'd8,    1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd2,    16'd2,    2, 16'd8,    1'b0, 3'b000);
    add_vec(OP_IF_GT, 16'd0,    16'd0,    0, 16'd8,    1'b1, 3'b000);
    add_vec(OP_PUSH,  16'd2,    16'd2,    1, 16'd8,    1'b1, 3'b000);
    add_vec(OP_PUSH,  16'd4,    16'd4,    2, 16'd8,    1'b1, 3'b000);
    add_vec(OP_CMP,   16'd0,    16'hFFFF, 1, 16'hFFFF, 1'b1, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd0,    0, 16'hFFFF, 1'b1, 3'b000);
    add_vec(OP_PUSH,  16'h00F0, 16'h00F0, 1, 16'hFFFF, 1'b1, 3'b000);
    add_vec(OP_NOT,   16'd0,    16'hFF0F, 1, 16'hFF0F, 1'b1, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd0,    0, 16'hFF0F, 1'b1, 3'b000);
    add_vec(OP_ADD,   16'd0,    16'd0,    0, 16'hFF0F, 1'b1, 3'b010);
    add_vec(OP_NOP,   16'd0,    16'd0,    0, 16'hFF0F, 1'b1, 3'b000);
    add_vec(OP_PUSH,  16'd7,    16'd7,    1, 16'hFF0F, 1'b1, 3'b000);
    add_vec(OP_PUSH,  16'd0,    16'd0,    2, 16'hFF0F, 1'b1, 3'b000);
    add_vec(OP_DIV,   16'd0,    16'hFFFF, 1, 16'hFFFF, 1'b1, 3'b001);
    add_vec(OP_PUSH,  16'h8000, 16'h8000, 2, 16'hFFFF, 1'b1, 3'b000);
    add_vec(OP_IF_LT, 16'd0,    16'd0,    0, 16'hFFFF, 1'b0, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd0,    0, 16'hFFFF, 1'b0, 3'b010);
    add_vec(OP_DUP,   16'd0,    16'd0,    0, 16'hFFFF, 1'b0, 3'b010);
    add_vec(OP_PUSH,  16'd3,    16'd3,    1, 16'hFFFF, 1'b0, 3'b000);
    add_vec(OP_DUP,   16'd0,    16'd3,    2, 16'hFFFF, 1'b0, 3'b000);
    add_vec(OP_PUSH,  16'd5,    16'd5,    3, 16'hFFFF, 1'b0, 3'b000);
    add_vec(OP_SWAP,  16'd0,    16'd3,    3, 16'hFFFF, 1'b0, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd5,    2, 16'd3,    1'b0, 3'b000);
    add_vec(OP_XOR,   16'd0,    16'd6,    1, 16'd6,    1'b0, 3'b000);
    add_vec(OP_POP,   16'd0,    16'd0,    0, 16'd6,    1'b0, 3'b000);

    // Reset state, observed while reset is still asserted.
    #23;
    check("reset depth", 32'(depth), 32'd0);
    check("reset tos",   32'(tos),   32'd0);
    check("reset dout",  32'(dout),  32'd0);
    check("reset busy",  32'(busy),  32'd0);
    check("reset ready", 32'(cmd_ready), 32'd1);
    check("reset cond",  32'(cond_flag), 32'd0);
    check("reset errs",  32'({err_ovf, err_udf, err_dz}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].data);
      wait_idle();
      check($sformatf("vec%0d tos", i),   32'(tos),       32'(vecs[i].tos));
      check($sformatf("vec%0d depth", i), 32'(depth),     32'(vecs[i].depth));
      check($sformatf("vec%0d dout", i),  32'(dout),      32'(vecs[i].dout));
      check($sformatf("vec%0d cond", i),  32'(cond_flag), 32'(vecs[i].cond));
      check($sformatf("vec%0d err", i),   32'({err_ovf, err_udf, err_dz}), 32'(vecs[i].err));
    end

    // Divider timing with a PUSH held valid throughout the busy window.
    apply_reset();
    issue(OP_PUSH, 16'd4);
    issue(OP_PUSH, 16'd2);
    cmd_valid = 1'b1;
    cmd_op    = OP_DIV;
    @(negedge clk);
    cmd_op   = OP_PUSH;
    cmd_data = 16'd9;
    n = 0;
    while (busy && n < 40) begin
      n++;
      check("div ready low", 32'(cmd_ready), 32'd0);
      check("div depth held", 32'(depth), 32'd2);
      @(negedge clk);
    end
    check("div busy cycles", 32'(n), 32'd16);
    check("div result tos",  32'(tos),   32'd2);
    check("div result depth", 32'(depth), 32'd1);
    check("div result dout", 32'(dout),  32'd2);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held push tos",   32'(tos),   32'd9);
    check("held push depth", 32'(depth), 32'd2);

    // Overflow on a full stack.
    apply_reset();
    for (int i = 0; i < D; i++) issue(OP_PUSH, W'(i + 1));
    check("full depth", 32'(depth), 32'(D));
    issue(OP_PUSH, 16'd99);
    check("ovf pulse", 32'(err_ovf), 32'd1);
    check("ovf only",  32'({err_udf, err_dz}), 32'd0);
    check("ovf depth", 32'(depth), 32'(D));
    check("ovf tos",   32'(tos),   32'(D));
    @(negedge clk);
    check("ovf single", 32'(err_ovf), 32'd0);
    issue(OP_DUP, 16'd0);
    check("dup ovf pulse", 32'(err_ovf), 32'd1);
    check("dup ovf tos",   32'(tos),     32'(D));

    // Underflow from empty.
    apply_reset();
    issue(OP_ADD, 16'd0);
    check("udf pulse", 32'(err_udf), 32'd1);
    check("udf depth", 32'(depth),   32'd0);
    @(negedge clk);
    check("udf single", 32'(err_udf), 32'd0);

    // Divide by zero completes in one cycle.
    issue(OP_PUSH, 16'd7);
    issue(OP_PUSH, 16'd0);
    issue(OP_DIV, 16'd0);
    check("dz busy",  32'(busy),   32'd0);
    check("dz tos",   32'(tos),    32'hFFFF);
    check("dz pulse", 32'(err_dz), 32'd1);
    check("dz depth", 32'(depth),  32'd1);
    @(negedge clk);
    check("dz single", 32'(err_dz), 32'd0);

    // Reset asserted in the middle of a division.
    apply_reset();
    issue(OP_PUSH, 16'd9);
    issue(OP_PUSH, 16'd3);
    issue(OP_DIV, 16'd0);
    repeat (4) @(negedge clk);
    check("mid div busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort depth", 32'(depth), 32'd0);
    check("abort busy",  32'(busy),  32'd0);
    check("abort tos",   32'(tos),   32'd0);
    check("abort ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(OP_PUSH, 16'd1);
    check("post abort tos",   32'(tos),   32'd1);
    check("post abort depth", 32'(depth), 32'd1);
    repeat (20) @(negedge clk);
    check("post abort stable", 32'({tos, 11'(depth), busy}), 32'({16'd1, 11'd1, 1'b0}));

    // Randomized commands against the reference model.
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 19));
      if ($urandom_range(0, 2) == 0) op = OP_PUSH;
      cmd_data = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      issue(op, cmd_data);
      model_step(op, cmd_data);
      wait_idle();
      compare_model($sformatf("rnd%0d op%0d", i, op));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_alu_engine.md
Name: stack_alu_engine

Overview:
- Single-clock, parametrised successor to the stack/temp/ULA datapath.
- Replaces the separate stack and temp clocks and strobes with one command interface using a valid/ready handshake.
- Holds an internal operand stack of DEPTH words, each WIDTH bits wide, and executes stack, ALU and compare opcodes on TOS/NOS.
- Adds a multi-cycle divider, overflow/underflow/div-by-zero reporting and a condition flag for the control unit.

Parameters:
- WIDTH, 16, data word width (>=4)
- DEPTH, 16, stack entries (>=2)
- CW, $clog2(DEPTH+1), width of depth count (derived)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command (= !busy)
- cmd_op  in  5  opcode (stack_pkg encoding)
- cmd_data  in  WIDTH  immediate for PUSH
- tos  out  WIDTH  top of stack; 0 when empty
- dout  out  WIDTH  result of last completed op (ALU result or popped word)
- depth  out  CW  number of valid entries
- busy  out  1  divider in progress
- cond_flag  out  1  result of last If_* compare
- err_ovf  out  1  one-cycle pulse: push onto full stack
- err_udf  out  1  one-cycle pulse: insufficient operands
- err_dz  out  1  one-cycle pulse: divide by zero

Behaviour:
- Reset: depth=0, tos=0, dout=0, busy=0, cond_flag=0, all err_*=0, cmd_ready=1. Reset asserted mid-division aborts it and clears the stack.
- A command is accepted on a rising edge with cmd_valid&&cmd_ready. Commands presented while busy are not accepted, and no state changes.
- Operand naming: T=TOS, N=entry below T. Binary ops compute N op T, pop 2, push result (depth-1).
- Opcodes:
  - NOP
  - PUSH: push cmd_data
  - POP: dout=T, depth-1
  - DUP
  - SWAP
  - Add, Sub, Mul, And, Nand, Or, Xor: binary ops
  - Not: unary, replaces T
  - Cmp: binary, pushes signed compare result: -1 if N<T, 0 if equal, +1 if N>T
  - Div: binary
  - If_eq, If_gt, If_lt, If_ge, If_le: signed N vs T; pop 2, push nothing, cond_flag=result
- Operands required: 0 for NOP/PUSH; 1 for POP/DUP/Not; 2 for all others.
- Arithmetic: two's complement, wrap modulo 2^WIDTH. Mul keeps the low WIDTH bits. Div is unsigned quotient, remainder discarded.
- Latency, single-cycle ops: tos/depth/dout/cond_flag are updated at the acceptance edge and visible the following cycle.
- Div state machine:
  - IDLE --accept Div, T!=0--> DIV.
  - DIV runs WIDTH iterations of restoring division, one per cycle; busy=1, cmd_ready=0.
  - After the last iteration, return to IDLE and write the quotient (pop 2, push Q, dout=Q).
  - Result is visible WIDTH+1 cycles after acceptance.
- Div with T==0: completes in one cycle, pushes all-ones, err_dz pulses, no DIV state.
- Boundaries:
  - PUSH or DUP at depth==DEPTH: err_ovf pulses, stack unchanged.
  - Any op with depth < required operands: err_udf pulses, stack, dout and cond_flag unchanged, no DIV entry.
  - NOP never flags.
  - Only one err_* can pulse per accepted command.
- tos is combinational from storage. All other outputs are registered.

Decomposition:
- Package stack_pkg holds:
  - opcode localparams (5-bit): NOP=0, PUSH=1, POP=2, DUP=3, SWAP=4, Add=5, Sub=6, Mul=7, Div=8, And=9, Nand=10, Or=11, Xor=12, Cmp=13, Not=14, If_eq=15, If_gt=16, If_lt=17, If_ge=18, If_le=19
  - a function returning required operand count per opcode
  - FSM state encoding: IDLE, DIV
- Sub-module serial_divider: parametrised WIDTH, start/done handshake, dividend/divisor in, quotient out.
- The stack array and the single-cycle ALU stay in stack_alu_engine.

Test Plan:
- Reset, then PUSH 4, PUSH 2, Add -> tos=6, depth=1, dout=6; repeat with Sub -> tos=2; Mul -> tos=8.
- PUSH 4, PUSH 2, Div -> busy=1 and cmd_ready=0 for 16 cycles; at cycle 17 tos=2, depth=1; a PUSH held valid during busy is accepted only after busy falls.
- PUSH 4, PUSH 2, If_gt -> cond_flag=1, depth=0; PUSH 2, PUSH 4, Cmp -> tos=16'hFFFF; PUSH 0x00F0, Not -> tos=16'hFF0F.
- Fill 16 PUSHes, then a 17th -> err_ovf single pulse, depth=16, tos unchanged; from empty, Add -> err_udf pulse, depth=0.
- PUSH 7, PUSH 0, Div -> one cycle, tos=16'hFFFF, err_dz pulse, busy stays 0.
- Start Div with 9/3, drop reset_n at cycle 5 of DIV -> immediately depth=0, busy=0, tos=0; after release, PUSH 1 works normally.
